// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: FSM state encodings and button indices for the ALU front panel
package alu_sequencer_pkg;
    localparam logic [1:0] LOAD_A  = 2'd0;
    localparam logic [1:0] LOAD_B  = 2'd1;
    localparam logic [1:0] LOAD_OP = 2'd2;
    localparam logic [1:0] SHOW    = 2'd3;
    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;
endpackage

// File: rtl/alu_sequencer_button_debounce.sv
// button_debounce: synchronizes and debounces one raw button, pulsing PRESS once per debounced rising edge
module button_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic RAW,
    output logic LEVEL,
    output logic PRESS
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic level_d;
    logic differ;
    logic done;
    always_comb begin
        differ = sync[1] != LEVEL;
        done   = differ && cnt == CW'(DEB_CYCLES - 1);
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync    <= '0;
            cnt     <= '0;
            LEVEL   <= 1'b0;
            level_d <= 1'b0;
            PRESS   <= 1'b0;
        end else begin
            sync    <= {sync[0], RAW};
            cnt     <= (!differ || done) ? '0 : cnt + 1'b1;
            LEVEL   <= done ? sync[1] : LEVEL;
            level_d <= LEVEL;
            PRESS   <= LEVEL & ~level_d;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: front-panel controller enforcing the A -> B -> OP load order for the ALU
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SWITCH,
    input  logic [2:0] BOT,
    input  logic [7:0] ALU_Z,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [7:0] ALU_OP,
    output logic [7:0] LED,
    output logic [1:0] STATE,
    output logic       RESULT_VALID
);
    logic [2:0] press;
    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .CLK(CLK), .RST(RST), .RAW(BOT[i]), .LEVEL(), .PRESS(press[i])
        );
    end
    assign RESULT_VALID = STATE == SHOW;
    // else-if chain gives PRESS[0] > PRESS[1] > PRESS[2] priority
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_A  <= '0;
            ALU_B  <= '0;
            ALU_OP <= '0;
            LED    <= '0;
            STATE  <= LOAD_A;
        end else begin
            LED <= (STATE == SHOW) ? ALU_Z : SWITCH;
            if (press[BTN_A]) begin
                ALU_A <= SWITCH;
                STATE <= LOAD_B;
            end else if (press[BTN_B] && STATE != LOAD_A) begin
                ALU_B <= SWITCH;
                STATE <= (STATE == LOAD_B) ? LOAD_OP : STATE;
            end else if (press[BTN_OP] && (STATE == LOAD_OP || STATE == SHOW)) begin
                ALU_OP <= SWITCH;
                STATE  <= SHOW;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed-vector bench for alu_sequencer with a small model ALU
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = '0;
    logic [2:0] bot = '0;
    logic [7:0] alu_z, alu_a, alu_b, alu_op, led;
    logic [1:0] state;
    logic       result_valid;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign alu_z = (alu_op == 8'h01) ? alu_a + alu_b :
                   (alu_op == 8'h02) ? alu_a - alu_b : 8'h00;

    alu_sequencer #(.DEB_CYCLES(4)) dut (
        .CLK(clk), .RST(rst), .SWITCH(sw), .BOT(bot), .ALU_Z(alu_z),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op), .LED(led),
        .STATE(state), .RESULT_VALID(result_valid)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        bot = mask;
        cycles(hold);
        bot = '0;
        cycles(12);
    endtask

    initial begin
        cycles(3);
        check("reset_a", alu_a, 8'h00);
        check("reset_b", alu_b, 8'h00);
        check("reset_op", alu_op, 8'h00);
        check("reset_led", led, 8'h00);
        check("reset_state", {6'd0, state}, 8'd0);
        check("reset_valid", {7'd0, result_valid}, 8'd0);
        rst = 1'b0;
        sw = 8'h77;
        cycles(2);
        check("led_preview", led, 8'h77);
        press(3'b100, 10);
        check("ooo_op_state", {6'd0, state}, 8'd0);
        check("ooo_op_reg", alu_op, 8'h00);
        // held A button: one load, later switch change must not be captured
        sw = 8'h12;
        bot = 3'b001;
        cycles(100);
        check("held_a_mid", alu_a, 8'h12);
        sw = 8'h99;
        cycles(100);
        bot = '0;
        cycles(12);
        check("held_a_reg", alu_a, 8'h12);
        check("held_a_state", {6'd0, state}, 8'd1);
        // 2-cycle bounces on B must be rejected
        sw = 8'h34;
        for (int i = 0; i < 30; i++) begin
            bot = (i % 4 < 2) ? 3'b010 : 3'b000;
            cycles(1);
        end
        bot = '0;
        cycles(12);
        check("bounce_b_reg", alu_b, 8'h00);
        check("bounce_b_state", {6'd0, state}, 8'd1);
        press(3'b010, 10);
        check("hold_b_reg", alu_b, 8'h34);
        check("hold_b_state", {6'd0, state}, 8'd2);
        // simultaneous A and OP in LOAD_OP: A wins
        sw = 8'h55;
        press(3'b101, 10);
        check("simul_a_reg", alu_a, 8'h55);
        check("simul_op_reg", alu_op, 8'h00);
        check("simul_state", {6'd0, state}, 8'd1);
        // full sequence to SHOW
        sw = 8'h12;
        press(3'b001, 10);
        check("seq_a_reg", alu_a, 8'h12);
        check("seq_a_state", {6'd0, state}, 8'd1);
        sw = 8'h34;
        press(3'b010, 10);
        check("seq_b_reg", alu_b, 8'h34);
        check("seq_b_state", {6'd0, state}, 8'd2);
        sw = 8'h01;
        bot = 3'b100;
        for (int i = 0; i < 20 && state != 2'd3; i++) cycles(1);
        check("seq_op_state", {6'd0, state}, 8'd3);
        check("seq_op_reg", alu_op, 8'h01);
        check("seq_valid", {7'd0, result_valid}, 8'd1);
        check("seq_led_entry", led, 8'h01);
        cycles(1);
        check("seq_led_result", led, 8'h46);
        bot = '0;
        cycles(12);
        // re-operation while in SHOW
        sw = 8'h02;
        bot = 3'b100;
        for (int i = 0; i < 20 && alu_op != 8'h02; i++) cycles(1);
        check("reop_reg", alu_op, 8'h02);
        check("reop_state", {6'd0, state}, 8'd3);
        check("reop_led_old", led, 8'h46);
        cycles(1);
        check("reop_led_new", led, 8'hde);
        bot = '0;
        cycles(12);
        // asynchronous reset in the middle of a debounce count
        sw = 8'hab;
        bot = 3'b001;
        cycles(4);
        #2 rst = 1'b1;
        #1;
        check("arst_a", alu_a, 8'h00);
        check("arst_b", alu_b, 8'h00);
        check("arst_op", alu_op, 8'h00);
        check("arst_led", led, 8'h00);
        check("arst_state", {6'd0, state}, 8'd0);
        check("arst_valid", {7'd0, result_valid}, 8'd0);
        bot = '0;
        cycles(3);
        rst = 1'b0;
        cycles(20);
        check("post_rst_a", alu_a, 8'h00);
        check("post_rst_state", {6'd0, state}, 8'd0);
        press(3'b001, 10);
        check("post_rst_press_a", alu_a, 8'hab);
        check("post_rst_press_state", {6'd0, state}, 8'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
